// File: rtl/cg_iteration_controller.sv
// Iteration sequencer for the conjugate-gradient ALU: drives ALU/engine resets, tracks
// per-iteration completion, ping-pongs the P/R/X banks and stops on convergence, MAX_ITER or watchdog.
module cg_iteration_controller #(
    parameter int MAX_ITER      = 64,
    parameter int ITER_W        = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int WATCHDOG      = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              solve_start,
    input  logic              vXv1_finish,
    input  logic              mXv1_finish,
    input  logic              mul_add3_finish,
    input  logic              finish_all,
    output logic              alu_reset,
    output logic              reset_vXv1,
    output logic              reset_mXv1,
    output logic              buf_sel,
    output logic [ITER_W-1:0] iter_count,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              timed_out
);

    localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam int WD_W  = $clog2(WATCHDOG + 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(WATCHDOG - 1);
    localparam logic [WD_W-1:0]   WD_MAX      = WD_W'(WATCHDOG);
    localparam logic [ITER_W-1:0] ITER_LIMIT  = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_PHASE1 = 3'd2,
        ST_PHASE2 = 3'd3,
        ST_SWAP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [SET_W-1:0]  settle_cnt_r;
    logic [WD_W-1:0]   wd_cnt_r;
    logic              v_flag_r;
    logic              m_flag_r;
    logic              eng_rst_r;
    logic              buf_sel_r;
    logic [ITER_W-1:0] iter_count_r;
    logic              busy_r;
    logic              done_r;
    logic              converged_r;
    logic              timed_out_r;

    logic both_s;
    logic wd_hit_s;
    logic accept_s;
    logic enter_swap_s;
    logic abort_s;

    assign both_s       = (v_flag_r | vXv1_finish) & (m_flag_r | mXv1_finish);
    assign wd_hit_s     = (wd_cnt_r >= WD_LAST);
    assign accept_s     = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && solve_start;
    assign enter_swap_s = (state_r == ST_PHASE2) && (state_next_s == ST_SWAP);
    // Any entry into DONE from an active state that finish_all did not cause is a timeout.
    assign abort_s      = (state_next_s == ST_DONE) &&
                          (state_r inside {ST_PHASE1, ST_PHASE2, ST_SWAP}) &&
                          !((state_r == ST_PHASE2) && finish_all);

    // Next-state selection; finish_all outranks watchdog, watchdog outranks progress.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:   if (solve_start) state_next_s = ST_INIT; else state_next_s = ST_IDLE;
            ST_INIT:   if (settle_cnt_r == SETTLE_LAST) state_next_s = ST_PHASE1; else state_next_s = ST_INIT;
            ST_PHASE1: begin
                if (wd_hit_s)    state_next_s = ST_DONE;
                else if (both_s) state_next_s = ST_PHASE2;
                else             state_next_s = ST_PHASE1;
            end
            ST_PHASE2: begin
                if (finish_all)           state_next_s = ST_DONE;
                else if (wd_hit_s)        state_next_s = ST_DONE;
                else if (mul_add3_finish) state_next_s = ST_SWAP;
                else                      state_next_s = ST_PHASE2;
            end
            ST_SWAP:   if (iter_count_r == ITER_LIMIT) state_next_s = ST_DONE; else state_next_s = ST_INIT;
            ST_DONE:   if (solve_start) state_next_s = ST_INIT; else state_next_s = ST_DONE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Settle and watchdog counters; the watchdog saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt_r <= {SET_W{1'b0}};
            wd_cnt_r     <= {WD_W{1'b0}};
        end else begin
            if ((state_r == ST_INIT) && (state_next_s == ST_INIT)) settle_cnt_r <= settle_cnt_r + SET_W'(1);
            else                                                   settle_cnt_r <= {SET_W{1'b0}};
            if (state_r inside {ST_PHASE1, ST_PHASE2}) begin
                if (wd_cnt_r != WD_MAX) wd_cnt_r <= wd_cnt_r + WD_W'(1);
                else                    wd_cnt_r <= wd_cnt_r;
            end else begin
                wd_cnt_r <= {WD_W{1'b0}};
            end
        end
    end

    // Sticky completion flags for the two phase-1 engines.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_flag_r <= 1'b0;
            m_flag_r <= 1'b0;
        end else if (state_r == ST_PHASE1) begin
            v_flag_r <= v_flag_r | vXv1_finish;
            m_flag_r <= m_flag_r | mXv1_finish;
        end else if (state_r == ST_PHASE2) begin
            v_flag_r <= v_flag_r;
            m_flag_r <= m_flag_r;
        end else begin
            v_flag_r <= 1'b0;
            m_flag_r <= 1'b0;
        end
    end

    // Registered outputs, computed from the upcoming state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            eng_rst_r    <= 1'b1;
            buf_sel_r    <= 1'b0;
            iter_count_r <= {ITER_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            converged_r  <= 1'b0;
            timed_out_r  <= 1'b0;
        end else begin
            eng_rst_r <= !(state_next_s inside {ST_PHASE1, ST_PHASE2, ST_SWAP});
            busy_r    <= (state_next_s inside {ST_INIT, ST_PHASE1, ST_PHASE2, ST_SWAP});
            done_r    <= (state_next_s == ST_DONE) && (state_r != ST_DONE);
            if (accept_s) begin
                buf_sel_r    <= 1'b0;
                iter_count_r <= {ITER_W{1'b0}};
                converged_r  <= 1'b0;
                timed_out_r  <= 1'b0;
            end else begin
                buf_sel_r    <= enter_swap_s ? ~buf_sel_r : buf_sel_r;
                iter_count_r <= enter_swap_s ? (iter_count_r + ITER_W'(1)) : iter_count_r;
                converged_r  <= converged_r | ((state_r == ST_PHASE2) && finish_all);
                timed_out_r  <= timed_out_r | abort_s;
            end
        end
    end

    assign alu_reset  = eng_rst_r;
    assign reset_vXv1 = eng_rst_r;
    assign reset_mXv1 = eng_rst_r;
    assign buf_sel    = buf_sel_r;
    assign iter_count = iter_count_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign converged  = converged_r;
    assign timed_out  = timed_out_r;

endmodule
